dmem_bus_bridge: RTL and testbench

//   Sits between the pipelined core's MEM-stage data port and a latency-variable data bus.

---
 rtl/dmem_bus_bridge.sv | 155 +++++++++++++++
 tb/tb_dmem_bus_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge
//   Bridges the core's single-cycle MEM-stage data port (ce/we/addr/wdata) onto a
//   valid/ready request channel and a valid/ready response channel. The core is
//   stalled until the access completes. Misaligned accesses are rejected locally.
//   A REQ+WAIT timeout aborts stuck accesses. A response that arrives after a WAIT
//   timeout is drained before the next request is issued.
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   core_ce_i/we_i       access request / store select
//   core_addr_i          byte address (must be word aligned)
//   core_wdata_i         store data
//   core_rdata_o         load data, valid in the completion cycle only
//   core_stall_o         pipeline freeze while an access is pending
//   core_err_o           one-cycle error pulse at completion (misaligned / timeout)
//   bus_req_*            request channel (valid/ready handshake, registered payload)
//   bus_resp_*           response channel (valid/ready handshake, read data)
module dmem_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_ce_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic [31:0] core_rdata_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        bus_req_valid_o,
  input  logic        bus_req_ready_i,
  output logic        bus_req_we_o,
  output logic [31:0] bus_req_addr_o,
  output logic [31:0] bus_req_wdata_o,
  input  logic        bus_resp_valid_i,
  input  logic [31:0] bus_resp_rdata_i,
  output logic        bus_resp_ready_o
);

  // Counter must be able to hold TIMEOUT itself: a handshake in the last REQ
  // cycle moves into WAIT with the count already past the limit.
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t             state_q;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic               stale_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               timeout_hit;

  // Budget exhausted; ">=" also covers WAIT entered on the final REQ cycle.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= CNT_LAST);

  // Control FSM with request/response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      stale_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (core_ce_i) begin
            we_q    <= core_we_i;
            addr_q  <= core_addr_i;
            wdata_q <= core_wdata_i;
            rdata_q <= '0;
            if (core_addr_i[1:0] != 2'b00) begin
              err_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              err_q   <= 1'b0;
              cnt_q   <= '0;
              // An abandoned response is still owed by the bus: absorb it first.
              state_q <= stale_q ? S_DRAIN : S_REQ;
            end
          end
        end
        S_REQ: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus_req_ready_i) begin
            state_q <= S_WAIT;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            state_q <= S_DONE;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus_resp_valid_i) begin
            rdata_q <= we_q ? 32'h0 : bus_resp_rdata_i;
            err_q   <= 1'b0;
            state_q <= S_DONE;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            stale_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        S_DRAIN: begin
          if (bus_resp_valid_i) begin
            stale_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_REQ;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Stall follows ce in IDLE so the core freezes in the request cycle itself;
  // reset forces it low because ce may still be held high by the core.
  always_comb begin
    core_stall_o = 1'b0;
    case (state_q)
      S_IDLE:                 core_stall_o = core_ce_i & ~rst;
      S_REQ, S_WAIT, S_DRAIN: core_stall_o = 1'b1;
      default:                core_stall_o = 1'b0;
    endcase
  end

  // Remaining outputs are pure decodes of registered state.
  assign core_rdata_o     = (state_q == S_DONE) ? rdata_q : 32'h0;
  assign core_err_o       = (state_q == S_DONE) & err_q;
  assign bus_req_valid_o  = (state_q == S_REQ);
  assign bus_req_we_o     = we_q;
  assign bus_req_addr_o   = addr_q;
  assign bus_req_wdata_o  = wdata_q;
  assign bus_resp_ready_o = (state_q == S_WAIT) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge
//   Directed bench for dmem_bus_bridge (TIMEOUT=8). Inputs change 1 time unit
//   after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_bus_bridge;

  logic        clk;
  logic        rst;
  logic        core_ce_i;
  logic        core_we_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wdata_i;
  logic [31:0] core_rdata_o;
  logic        core_stall_o;
  logic        core_err_o;
  logic        bus_req_valid_o;
  logic        bus_req_ready_i;
  logic        bus_req_we_o;
  logic [31:0] bus_req_addr_o;
  logic [31:0] bus_req_wdata_o;
  logic        bus_resp_valid_i;
  logic [31:0] bus_resp_rdata_i;
  logic        bus_resp_ready_o;

  int checks;
  int failures;

  dmem_bus_bridge #(.TIMEOUT(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .core_ce_i        (core_ce_i),
    .core_we_i        (core_we_i),
    .core_addr_i      (core_addr_i),
    .core_wdata_i     (core_wdata_i),
    .core_rdata_o     (core_rdata_o),
    .core_stall_o     (core_stall_o),
    .core_err_o       (core_err_o),
    .bus_req_valid_o  (bus_req_valid_o),
    .bus_req_ready_i  (bus_req_ready_i),
    .bus_req_we_o     (bus_req_we_o),
    .bus_req_addr_o   (bus_req_addr_o),
    .bus_req_wdata_o  (bus_req_wdata_o),
    .bus_resp_valid_i (bus_resp_valid_i),
    .bus_resp_rdata_i (bus_resp_rdata_i),
    .bus_resp_ready_o (bus_resp_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic stall, input logic valid,
                          input logic rready, input logic err, input logic [31:0] rdata);
    chk({tag, ".stall"}, 32'(core_stall_o), 32'(stall));
    chk({tag, ".req_valid"}, 32'(bus_req_valid_o), 32'(valid));
    chk({tag, ".resp_ready"}, 32'(bus_resp_ready_o), 32'(rready));
    chk({tag, ".err"}, 32'(core_err_o), 32'(err));
    chk({tag, ".rdata"}, core_rdata_o, rdata);
  endtask

  task automatic chk_payload(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata);
    chk({tag, ".we"}, 32'(bus_req_we_o), 32'(we));
    chk({tag, ".addr"}, bus_req_addr_o, addr);
    chk({tag, ".wdata"}, bus_req_wdata_o, wdata);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    rst              = 1'b1;
    core_ce_i        = 1'b0;
    core_we_i        = 1'b0;
    core_addr_i      = 32'h0;
    core_wdata_i     = 32'h0;
    bus_req_ready_i  = 1'b0;
    bus_resp_valid_i = 1'b0;
    bus_resp_rdata_i = 32'h0;

    // Reset state
    smp();
    chk_ctrl("rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_payload("rst", 1'b0, 32'h0, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    // Aligned load, ready immediately, response one cycle later
    core_ce_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h100; bus_req_ready_i = 1'b1;
    smp(); chk_ctrl("ld.idle", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    smp(); chk_ctrl("ld.req", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_payload("ld.req", 1'b0, 32'h100, 32'h0);
    cyc();
    bus_req_ready_i = 1'b0; bus_resp_valid_i = 1'b1; bus_resp_rdata_i = 32'hCAFEF00D;
    smp(); chk_ctrl("ld.wait", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    bus_resp_valid_i = 1'b0;
    smp(); chk_ctrl("ld.done", 1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D);
    cyc();
    core_ce_i = 1'b0;
    smp(); chk_ctrl("ld.after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc();

    // Store: ready after 4 REQ cycles, ack on the 2nd WAIT cycle
    core_ce_i = 1'b1; core_we_i = 1'b1; core_addr_i = 32'h204; core_wdata_i = 32'h12345678;
    smp(); chk_ctrl("st.idle", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      smp(); chk_ctrl("st.req_hold", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      chk_payload("st.req_hold", 1'b1, 32'h204, 32'h12345678);
      cyc();
    end
    bus_req_ready_i = 1'b1;
    smp(); chk_ctrl("st.req_acc", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_payload("st.req_acc", 1'b1, 32'h204, 32'h12345678);
    cyc();
    bus_req_ready_i = 1'b0;
    smp(); chk_ctrl("st.wait1", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    bus_resp_valid_i = 1'b1; bus_resp_rdata_i = 32'hDEADBEEF;
    smp(); chk_ctrl("st.wait2", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk_payload("st.wait2", 1'b1, 32'h204, 32'h12345678);
    cyc();
    bus_resp_valid_i = 1'b0;
    smp(); chk_ctrl("st.done", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    core_ce_i = 1'b0; core_we_i = 1'b0; core_wdata_i = 32'h0;
    cyc();

    // Misaligned load: no bus traffic even with ready high
    core_ce_i = 1'b1; core_addr_i = 32'h102; bus_req_ready_i = 1'b1;
    smp(); chk_ctrl("mis.idle", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    smp(); chk_ctrl("mis.done", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    cyc();
    core_ce_i = 1'b0; bus_req_ready_i = 1'b0;
    smp(); chk_ctrl("mis.after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc();

    // REQ timeout: ready never comes, valid held exactly 8 cycles
    core_ce_i = 1'b1; core_addr_i = 32'h300;
    cyc();
    for (int i = 0; i < 8; i++) begin
      smp(); chk_ctrl("to_req.req", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc();
    end
    smp(); chk_ctrl("to_req.done", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    cyc();
    core_ce_i = 1'b0;
    smp(); chk_ctrl("to_req.after", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc();

    // WAIT timeout: accepted, response late -> error, then drain on next access
    core_ce_i = 1'b1; core_addr_i = 32'h400; bus_req_ready_i = 1'b1;
    cyc();
    smp(); chk_ctrl("to_wait.req", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc();
    bus_req_ready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      smp(); chk_ctrl("to_wait.wait", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      cyc();
    end
    smp(); chk_ctrl("to_wait.done", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    cyc();
    core_ce_i = 1'b0;
    cyc();
    core_ce_i = 1'b1; core_addr_i = 32'h500;
    smp(); chk_ctrl("drain.idle", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc();
    smp(); chk_ctrl("drain.hold", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    bus_resp_valid_i = 1'b1; bus_resp_rdata_i = 32'hBAD0BAD0;
    smp(); chk_ctrl("drain.stale", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    bus_resp_valid_i = 1'b0; bus_req_ready_i = 1'b1;
    smp(); chk_ctrl("drain.req", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_payload("drain.req", 1'b0, 32'h500, 32'h0);
    cyc();
    bus_req_ready_i = 1'b0; bus_resp_valid_i = 1'b1; bus_resp_rdata_i = 32'h5A5A1234;
    smp(); chk_ctrl("drain.wait", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    bus_resp_valid_i = 1'b0;
    smp(); chk_ctrl("drain.done", 1'b0, 1'b0, 1'b0, 1'b0, 32'h5A5A1234);
    cyc();
    core_ce_i = 1'b0;
    cyc();

    // Handshake on the last allowed REQ cycle and response in the same cycle
    // as the exhausted budget: both complete normally
    core_ce_i = 1'b1; core_addr_i = 32'h600;
    cyc();
    for (int i = 0; i < 7; i++) begin
      smp(); chk_ctrl("win.req", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc();
    end
    bus_req_ready_i = 1'b1;
    smp(); chk_ctrl("win.req_last", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cyc();
    bus_req_ready_i = 1'b0; bus_resp_valid_i = 1'b1; bus_resp_rdata_i = 32'h0F0F0F0F;
    smp(); chk_ctrl("win.wait", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    bus_resp_valid_i = 1'b0;
    smp(); chk_ctrl("win.done", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0F0F0F0F);
    cyc();
    core_ce_i = 1'b0;
    cyc();

    // Asynchronous reset while in WAIT
    core_ce_i = 1'b1; core_addr_i = 32'h700; bus_req_ready_i = 1'b1;
    cyc();
    cyc();
    bus_req_ready_i = 1'b0;
    smp(); chk_ctrl("arst.wait", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk_ctrl("arst.in", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk_payload("arst.in", 1'b0, 32'h0, 32'h0);
    cyc();
    rst = 1'b0; core_ce_i = 1'b0;
    smp(); chk_ctrl("arst.idle", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc();

    // Normal load after reset (no drain expected)
    core_ce_i = 1'b1; core_addr_i = 32'h800; bus_req_ready_i = 1'b1;
    cyc();
    smp(); chk_ctrl("post.req", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_payload("post.req", 1'b0, 32'h800, 32'h0);
    cyc();
    bus_req_ready_i = 1'b0; bus_resp_valid_i = 1'b1; bus_resp_rdata_i = 32'h13579BDF;
    smp(); chk_ctrl("post.wait", 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cyc();
    bus_resp_valid_i = 1'b0;
    smp(); chk_ctrl("post.done", 1'b0, 1'b0, 1'b0, 1'b0, 32'h13579BDF);
    cyc();
    core_ce_i = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
